// File: rtl/fp_mult_arbiter.sv
// Round-robin arbiter sharing one multi-cycle FP multiplier among NUM_REQ
// requesters. Operands are latched at grant, the multiplier is driven with an
// enable held until done, and a watchdog turns a hung multiplier into a quiet
// NaN result flagged by err. Each operation ends with a one-cycle ack.
module fp_mult_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [32*NUM_REQ-1:0]  req_dataa,
  input  logic [32*NUM_REQ-1:0]  req_datab,
  output logic [NUM_REQ-1:0]     ack,
  output logic [31:0]            result,
  output logic                   err,
  output logic                   busy,
  output logic                   mult_enable,
  output logic [31:0]            mult_dataa,
  output logic [31:0]            mult_datab,
  input  logic [31:0]            mult_result,
  input  logic                   mult_done
);

  localparam int          IDX_W = $clog2(NUM_REQ);
  localparam int          CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [31:0] QNAN  = 32'h7FC00000;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] rr_win;
  logic [CNT_W-1:0] wd_cnt;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;

  // First requester found searching from last+1 upward with wrap-around.
  // Walking the offsets from farthest to nearest lets the nearest one win.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] idx_l;
    int               idx;
    pick = last;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx   = (int'(last) + i) % NUM_REQ;
      idx_l = IDX_W'(idx);
      if (r[idx_l]) pick = idx_l;
    end
    return pick;
  endfunction

  function automatic logic [NUM_REQ-1:0] one_hot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

  // Round-robin winner and its operand pair, consumed only in IDLE.
  always_comb begin
    rr_win = rr_pick(req, last_grant);
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rr_win == IDX_W'(i)) begin
        sel_a = req_dataa[32*i +: 32];
        sel_b = req_datab[32*i +: 32];
      end
    end
  end

  // Control FSM with all outputs registered; RESP forces an enable-low gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= IDX_W'(NUM_REQ - 1);
      grant_idx   <= '0;
      wd_cnt      <= '0;
      ack         <= '0;
      result      <= '0;
      err         <= 1'b0;
      busy        <= 1'b0;
      mult_enable <= 1'b0;
      mult_dataa  <= '0;
      mult_datab  <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant_idx   <= rr_win;
            last_grant  <= rr_win;
            mult_dataa  <= sel_a;
            mult_datab  <= sel_b;
            wd_cnt      <= '0;
            mult_enable <= 1'b1;
            busy        <= 1'b1;
            state       <= BUSY;
          end
        end
        BUSY: begin
          wd_cnt <= wd_cnt + CNT_W'(1);
          if (mult_done) begin
            result      <= mult_result;
            err         <= 1'b0;
            mult_enable <= 1'b0;
            ack         <= one_hot(grant_idx);
            state       <= RESP;
          end else if (wd_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            result      <= QNAN;
            err         <= 1'b1;
            mult_enable <= 1'b0;
            ack         <= one_hot(grant_idx);
            state       <= RESP;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Bench for fp_mult_arbiter: directed scenarios followed by a randomized
// phase scored against a cycle-level model of the arbitration rules.
module tb_fp_mult_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [32*N-1:0] req_dataa;
  logic [32*N-1:0] req_datab;
  logic [N-1:0]    ack;
  logic [31:0]     result;
  logic            err;
  logic            busy;
  logic            mult_enable;
  logic [31:0]     mult_dataa;
  logic [31:0]     mult_datab;
  logic [31:0]     mult_result;
  logic            mult_done;

  logic [31:0] op_a [N];
  logic [31:0] op_b [N];

  int checks = 0;
  int errors = 0;

  // Multiplier model controls
  int lat     = 5;
  bit stuck   = 1'b0;
  bit x_done  = 1'b0;
  int en_cnt  = 0;

  always #5 clk = ~clk;

  fp_mult_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_dataa(req_dataa), .req_datab(req_datab),
    .ack(ack), .result(result), .err(err), .busy(busy), .mult_enable(mult_enable),
    .mult_dataa(mult_dataa), .mult_datab(mult_datab), .mult_result(mult_result),
    .mult_done(mult_done)
  );

  always_comb begin
    req_dataa = '0;
    req_datab = '0;
    for (int i = 0; i < N; i++) begin
      req_dataa[32*i +: 32] = op_a[i];
      req_datab[32*i +: 32] = op_b[i];
    end
  end

  // Truncating single-precision multiply for normal operands.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    logic [22:0] frac;
    int          e;
    m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (m[47]) begin
      frac = m[46:24];
      e    = e + 1;
    end else begin
      frac = m[45:23];
    end
    return {a[31] ^ b[31], 8'(e), frac};
  endfunction

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  function automatic int rr_next(input int last, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++)
      if (((r >> ((last + k) % N)) & 1) != 0) return (last + k) % N;
    return -1;
  endfunction

  // Multiplier: done in the lat-th consecutive enable cycle unless stuck.
  always @(posedge clk) en_cnt <= mult_enable ? en_cnt + 1 : 0;
  assign mult_done   = x_done | (!stuck && mult_enable && en_cnt == lat - 1);
  assign mult_result = fmul(mult_dataa, mult_datab);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack"},    32'(ack), 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_err"},    32'(err), 0);
    chk({tag, "_busy"},   32'(busy), 0);
    chk({tag, "_en"},     32'(mult_enable), 0);
    chk({tag, "_da"},     mult_dataa, 0);
    chk({tag, "_db"},     mult_datab, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          exp_order [5];
    int          n;
    logic [31:0] saved;
    logic [31:0] r6a, r6b;
    // random-phase model state
    logic [N-1:0] p_req;
    logic [31:0]  p_a [N];
    logic [31:0]  p_b [N];
    int           last, w, left;
    bit           in_flight, cool;
    logic [31:0]  exp_res;

    exp_order = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    req   = '0;
    for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; end
    tick();
    tick();
    chk_reset_vals("rst");
    reset = 1'b0;

    // Single requester 1: 3.0 * 2.0, latency 5
    lat = 5;
    op_a[1] = 32'h40400000;
    op_b[1] = 32'h40000000;
    req = 4'b0010;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("t1_en", 32'(mult_enable), 1);
      chk("t1_ack_low", 32'(ack), 0);
      if (k == 1) chk("t1_dataa", mult_dataa, 32'h40400000);
    end
    tick();
    chk("t1_ack", 32'(ack), 32'b0010);
    chk("t1_result", result, 32'h40C00000);
    chk("t1_err", 32'(err), 0);
    chk("t1_en_low", 32'(mult_enable), 0);
    req = '0;
    tick();
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_idle_ack", 32'(ack), 0);

    // All four held: round-robin order from a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    lat = 3;
    for (int i = 0; i < N; i++) begin op_a[i] = rnd_fp(); op_b[i] = rnd_fp(); end
    req = 4'b1111;
    n = 0;
    for (int k = 0; k < 80 && n < 5; k++) begin
      tick();
      if (ack != 0) begin
        chk("t2_order", 32'(ack), 32'(1) << exp_order[n]);
        chk("t2_en_gap", 32'(mult_enable), 0);
        chk("t2_result", result, fmul(op_a[exp_order[n]], op_b[exp_order[n]]));
        n++;
        if (n == 5) req = '0;
      end
    end
    chk("t2_ack_count", 32'(n), 5);
    tick();
    tick();

    // Requester 2 changes operand A mid-flight
    lat = 4;
    op_a[2] = 32'h3F800000;
    op_b[2] = 32'h40000000;
    req = 4'b0100;
    tick();
    chk("t3_dataa_grant", mult_dataa, 32'h3F800000);
    op_a[2] = 32'h41200000;
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk("t3_dataa_hold", mult_dataa, 32'h3F800000);
    end
    tick();
    chk("t3_ack", 32'(ack), 32'b0100);
    chk("t3_result", result, 32'h40000000);
    chk("t3_dataa_resp", mult_dataa, 32'h3F800000);
    req = '0;
    tick();

    // Watchdog: multiplier never completes
    stuck = 1'b1;
    op_a[3] = rnd_fp();
    op_b[3] = rnd_fp();
    req = 4'b1000;
    for (int k = 1; k <= TO; k++) begin
      tick();
      chk("t4_en", 32'(mult_enable), 1);
      chk("t4_ack_low", 32'(ack), 0);
    end
    tick();
    chk("t4_ack", 32'(ack), 32'b1000);
    chk("t4_err", 32'(err), 1);
    chk("t4_result", result, 32'h7FC00000);
    chk("t4_en_low", 32'(mult_enable), 0);
    req = '0;
    tick();
    chk("t4_idle_busy", 32'(busy), 0);
    stuck = 1'b0;

    // Reset in the third BUSY cycle of requester 1
    lat = 6;
    r6a = rnd_fp();
    r6b = rnd_fp();
    op_a[1] = r6a;
    op_b[1] = r6b;
    req = 4'b0010;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk_reset_vals("t5_rst");
    reset = 1'b0;
    for (int k = 5; k <= 10; k++) begin
      tick();
      chk("t5_regrant_en", 32'(mult_enable), 1);
      chk("t5_no_ack", 32'(ack), 0);
    end
    tick();
    chk("t5_ack", 32'(ack), 32'b0010);
    chk("t5_result", result, fmul(r6a, r6b));
    chk("t5_err", 32'(err), 0);
    req = '0;
    tick();

    // Stray mult_done while idle
    saved  = result;
    x_done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 1) x_done = 1'b0;
      chk("t6_ack", 32'(ack), 0);
      chk("t6_busy", 32'(busy), 0);
      chk("t6_en", 32'(mult_enable), 0);
      chk("t6_result", result, saved);
    end

    // Randomized traffic against the arbitration model
    last      = 1;
    in_flight = 1'b0;
    cool      = 1'b0;
    w         = 0;
    left      = 0;
    exp_res   = '0;
    lat       = $urandom_range(1, 6);
    for (int c = 0; c < 600; c++) begin
      bit acked;
      acked = 1'b0;
      p_req = req;
      for (int i = 0; i < N; i++) begin p_a[i] = op_a[i]; p_b[i] = op_b[i]; end
      tick();
      if (cool) begin
        chk("rnd_cool_en", 32'(mult_enable), 0);
        chk("rnd_cool_busy", 32'(busy), 0);
        chk("rnd_cool_ack", 32'(ack), 0);
        cool = 1'b0;
      end else if (!in_flight) begin
        if (p_req != 0) begin
          w = rr_next(last, p_req);
          chk("rnd_grant_en", 32'(mult_enable), 1);
          chk("rnd_grant_da", mult_dataa, p_a[w]);
          chk("rnd_grant_db", mult_datab, p_b[w]);
          exp_res   = fmul(p_a[w], p_b[w]);
          last      = w;
          left      = lat;
          in_flight = 1'b1;
        end else begin
          chk("rnd_idle_en", 32'(mult_enable), 0);
          chk("rnd_idle_ack", 32'(ack), 0);
        end
      end else begin
        left--;
        if (left > 0) begin
          chk("rnd_busy_en", 32'(mult_enable), 1);
          chk("rnd_busy_ack", 32'(ack), 0);
        end else begin
          chk("rnd_ack", 32'(ack), 32'(1) << w);
          chk("rnd_result", result, exp_res);
          chk("rnd_err", 32'(err), 0);
          chk("rnd_ack_en", 32'(mult_enable), 0);
          in_flight = 1'b0;
          cool      = 1'b1;
          acked     = 1'b1;
          lat       = $urandom_range(1, 6);
        end
      end
      if (acked) req[w] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          op_a[i] = rnd_fp();
          op_b[i] = rnd_fp();
          req[i]  = 1'b1;
        end
      end
      if (in_flight && $urandom_range(0, 3) == 0) begin
        op_a[w] = rnd_fp();
        op_b[w] = rnd_fp();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
